writeback_unit: RTL and testbench

Parametrised writeback stage for the RV32 pipeline. It selects the register-file write value (link address, masked load data or ALU result) and sequences loads against a data memory with either a fixed, configurable latency or a valid handshake. While a load is outstanding it holds the memory address stable and asks the core to pause. It sits at the end of the pipeline, between the memory/ALU stage outputs and the register-file write port.

---
 rtl/writeback_unit.sv | 196 +++++++++++++++++++
 tb/tb_writeback_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// writeback_unit: RV32 writeback stage.
// Selects the register-file write value (link address, masked load data or ALU
// result) and sequences loads against data memory, either after a fixed latency
// or on a mem_valid handshake. While a load is in flight the memory address is
// held and the core is paused.
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   stall              freezes the FSM and latency counter
//   in_valid           an instruction is present in writeback
//   pc                 PC of that instruction (link address source)
//   alu_result         ALU result, also the load address
//   dcache_output      raw memory read word
//   mem_valid          read data valid (handshake mode only)
//   funct3             load type
//   reg_we, mem_rr     instruction writes rd / is a load
//   jump               JAL/JALR
//   writeback, wb_we   register-file write data / enable
//   addr               data-memory address
//   pause              core must hold the writeback instruction
//   misaligned         current load is misaligned for its size
module writeback_unit #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned LOAD_LATENCY  = 1,
  parameter int unsigned USE_MEM_VALID = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            in_valid,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] dcache_output,
  input  logic            mem_valid,
  input  logic [2:0]      funct3,
  input  logic            reg_we,
  input  logic            mem_rr,
  input  logic            jump,
  output logic [XLEN-1:0] writeback,
  output logic            wb_we,
  output logic [XLEN-1:0] addr,
  output logic            pause,
  output logic            misaligned
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic [2:0]        f3_q, f3_d;

  logic              load_req_c;
  logic              mis_addr_c;
  logic              mem_ready_c;
  logic [7:0]        lane_byte_c;
  logic [15:0]       lane_half_c;
  logic [XLEN-1:0]   load_data_c;

  // Size-based alignment check on the live address.
  always_comb begin
    load_req_c = in_valid & mem_rr;
    mis_addr_c = 1'b0;
    if (funct3 == 3'b001 || funct3 == 3'b101) begin
      mis_addr_c = alu_result[0];
    end else if (funct3 == 3'b010) begin
      mis_addr_c = |alu_result[1:0];
    end
  end

  // Byte-lane select and sign/zero extension using the captured address and type.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane_byte_c = dcache_output[7:0];
      2'd1:    lane_byte_c = dcache_output[15:8];
      2'd2:    lane_byte_c = dcache_output[23:16];
      default: lane_byte_c = dcache_output[31:24];
    endcase
    lane_half_c = addr_q[1] ? dcache_output[31:16] : dcache_output[15:0];
    case (f3_q)
      3'b000:  load_data_c = {{24{lane_byte_c[7]}}, lane_byte_c};
      3'b001:  load_data_c = {{16{lane_half_c[15]}}, lane_half_c};
      3'b100:  load_data_c = {24'd0, lane_byte_c};
      3'b101:  load_data_c = {16'd0, lane_half_c};
      default: load_data_c = dcache_output;
    endcase
  end

  // Read data is ready on the handshake or once the latency counter has drained.
  always_comb begin
    if (USE_MEM_VALID != 0) begin
      mem_ready_c = mem_valid;
    end else begin
      mem_ready_c = (cnt_q == '0);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counter and captured load registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      f3_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      data_q <= data_d;
      f3_q   <= f3_d;
    end
  end

  // Next-state and capture logic; stall freezes every transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    f3_d    = f3_q;
    case (state_q)
      S_IDLE: begin
        if (load_req_c && !mis_addr_c && !stall) begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(LOAD_LATENCY - 1);
          addr_d  = alu_result;
          f3_d    = funct3;
        end
      end
      S_WAIT: begin
        if (!stall) begin
          if (mem_ready_c) begin
            data_d  = load_data_c;
            state_d = S_DONE;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        // The completed load is still presented here, so a new request is ignored.
        if (!stall) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs; reset forces the quiet values without waiting for a clock edge.
  always_comb begin
    writeback  = (jump & reg_we) ? (pc + XLEN'(4)) : alu_result;
    wb_we      = 1'b0;
    addr       = alu_result;
    pause      = 1'b0;
    misaligned = 1'b0;
    if (reset_n) begin
      case (state_q)
        S_IDLE: begin
          if (load_req_c) begin
            misaligned = mis_addr_c;
            pause      = ~mis_addr_c;
          end else begin
            wb_we = in_valid & reg_we;
          end
        end
        S_WAIT: begin
          pause = 1'b1;
          addr  = addr_q;
        end
        S_DONE: begin
          wb_we     = 1'b1;
          writeback = data_q;
          addr      = addr_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        iv_a, iv_b;
  logic [31:0] pc, alu, dcache;
  logic        mem_valid;
  logic [2:0]  f3;
  logic        reg_we, mem_rr, jump;

  logic [31:0] a_wb, a_addr, b_wb, b_addr;
  logic        a_we, a_pause, a_mis, b_we, b_pause, b_mis;

  int n_cmp = 0;
  int n_err = 0;

  writeback_unit #(.XLEN(32), .LOAD_LATENCY(3), .USE_MEM_VALID(0)) u_fix (
    .clk(clk), .reset_n(reset_n), .stall(stall), .in_valid(iv_a), .pc(pc),
    .alu_result(alu), .dcache_output(dcache), .mem_valid(mem_valid),
    .funct3(f3), .reg_we(reg_we), .mem_rr(mem_rr), .jump(jump),
    .writeback(a_wb), .wb_we(a_we), .addr(a_addr), .pause(a_pause),
    .misaligned(a_mis)
  );

  writeback_unit #(.XLEN(32), .LOAD_LATENCY(1), .USE_MEM_VALID(1)) u_hs (
    .clk(clk), .reset_n(reset_n), .stall(stall), .in_valid(iv_b), .pc(pc),
    .alu_result(alu), .dcache_output(dcache), .mem_valid(mem_valid),
    .funct3(f3), .reg_we(reg_we), .mem_rr(mem_rr), .jump(jump),
    .writeback(b_wb), .wb_we(b_we), .addr(b_addr), .pause(b_pause),
    .misaligned(b_mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [2:0]  f3;
    logic        we;
    logic        rr;
    logic        jmp;
    logic [31:0] e_wb;
    logic        e_we;
    logic        e_pause;
    logic        e_mis;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic quiet();
    stall = 1'b0; iv_a = 1'b0; iv_b = 1'b0; pc = '0; alu = '0; dcache = '0;
    mem_valid = 1'b0; f3 = '0; reg_we = 1'b0; mem_rr = 1'b0; jump = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h40,       32'h1234,   3'b000, 1'b1, 1'b0, 1'b0, 32'h1234,   1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'h100,      32'h5555,   3'b000, 1'b1, 1'b0, 1'b1, 32'h104,    1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 32'h200,      32'hABCD,   3'b000, 1'b0, 1'b0, 1'b1, 32'hABCD,   1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 32'h0,        32'h77,     3'b000, 1'b1, 1'b0, 1'b0, 32'h77,     1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 32'h0,        32'h2001,   3'b010, 1'b1, 1'b1, 1'b0, 32'h0,      1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 32'h0,        32'h2003,   3'b001, 1'b1, 1'b1, 1'b0, 32'h0,      1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 32'h0,        32'h2005,   3'b101, 1'b1, 1'b1, 1'b0, 32'h0,      1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 32'h0,        32'h2002,   3'b010, 1'b1, 1'b1, 1'b0, 32'h0,      1'b0, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 32'h0,        32'h3001,   3'b010, 1'b1, 1'b1, 1'b0, 32'h0,      1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 32'hFFFFFFFC, 32'h9,      3'b000, 1'b1, 1'b0, 1'b1, 32'h0,      1'b1, 1'b0, 1'b0};

    // Reset with a write presented: outputs must stay quiet.
    quiet();
    reset_n = 1'b0;
    iv_a = 1'b1; reg_we = 1'b1; alu = 32'h55;
    #1;
    chk("reset a_we", 32'(a_we), 32'd0);
    chk("reset a_pause", 32'(a_pause), 32'd0);
    chk("reset b_pause", 32'(b_pause), 32'd0);
    chk("reset a_mis", 32'(a_mis), 32'd0);
    quiet();
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
    next_cycle();

    // Single-cycle IDLE behaviour on the fixed-latency instance.
    for (int i = 0; i < 10; i++) begin
      iv_a = vecs[i].iv; pc = vecs[i].pc; alu = vecs[i].alu; f3 = vecs[i].f3;
      reg_we = vecs[i].we; mem_rr = vecs[i].rr; jump = vecs[i].jmp;
      @(negedge clk);
      if (vecs[i].e_we) chk($sformatf("vec%0d wb", i), a_wb, vecs[i].e_wb);
      chk($sformatf("vec%0d we", i), 32'(a_we), 32'(vecs[i].e_we));
      chk($sformatf("vec%0d pause", i), 32'(a_pause), 32'(vecs[i].e_pause));
      chk($sformatf("vec%0d mis", i), 32'(a_mis), 32'(vecs[i].e_mis));
      chk($sformatf("vec%0d addr", i), a_addr, vecs[i].alu);
      next_cycle();
    end
    quiet();
    next_cycle();

    // Fixed latency 3, LB at 0x2003; address bus changes after entry.
    for (int c = 0; c <= 5; c++) begin
      iv_a = (c <= 4); mem_rr = (c <= 4); reg_we = 1'b1; f3 = 3'b000; pc = 32'h300;
      alu = (c == 0) ? 32'h2003 : 32'hFFFFFFF0;
      dcache = (c == 3) ? 32'h80FFFFFF : 32'h11111111;
      @(negedge clk);
      if (c <= 3) begin
        chk($sformatf("lb c%0d pause", c), 32'(a_pause), 32'd1);
        chk($sformatf("lb c%0d we", c), 32'(a_we), 32'd0);
        chk($sformatf("lb c%0d addr", c), a_addr, 32'h2003);
      end else if (c == 4) begin
        chk("lb c4 pause", 32'(a_pause), 32'd0);
        chk("lb c4 we", 32'(a_we), 32'd1);
        chk("lb c4 wb", a_wb, 32'hFFFFFF80);
        chk("lb c4 addr", a_addr, 32'h2003);
      end else begin
        chk("lb c5 pause", 32'(a_pause), 32'd0);
        chk("lb c5 we", 32'(a_we), 32'd0);
      end
      next_cycle();
    end
    quiet();
    next_cycle();

    // LBU at 0x2001 with stall for two WAIT cycles and one DONE cycle.
    for (int c = 0; c <= 8; c++) begin
      iv_a = (c <= 7); mem_rr = (c <= 7); reg_we = 1'b1; f3 = 3'b100;
      alu = 32'h2001;
      stall = (c == 2) || (c == 3) || (c == 6);
      dcache = (c == 5) ? 32'h0000A500 : 32'h5A5A5A5A;
      @(negedge clk);
      if (c <= 5) begin
        chk($sformatf("stl c%0d pause", c), 32'(a_pause), 32'd1);
        chk($sformatf("stl c%0d we", c), 32'(a_we), 32'd0);
      end else if (c <= 7) begin
        chk($sformatf("stl c%0d pause", c), 32'(a_pause), 32'd0);
        chk($sformatf("stl c%0d we", c), 32'(a_we), 32'd1);
        chk($sformatf("stl c%0d wb", c), a_wb, 32'h000000A5);
        chk($sformatf("stl c%0d addr", c), a_addr, 32'h2001);
      end else begin
        chk("stl c8 pause", 32'(a_pause), 32'd0);
        chk("stl c8 we", 32'(a_we), 32'd0);
      end
      next_cycle();
    end
    quiet();
    next_cycle();

    // Handshake LHU at 0x2002; mem_valid under stall must be ignored.
    for (int c = 0; c <= 7; c++) begin
      iv_b = (c <= 6); mem_rr = (c <= 6); reg_we = 1'b1; f3 = 3'b101;
      alu = 32'h2002;
      stall = (c == 4);
      mem_valid = (c >= 4) && (c <= 6);
      dcache = (c == 5) ? 32'hBEEF0000 : 32'h12340000;
      @(negedge clk);
      if (c <= 5) begin
        chk($sformatf("hs c%0d pause", c), 32'(b_pause), 32'd1);
        chk($sformatf("hs c%0d we", c), 32'(b_we), 32'd0);
        chk($sformatf("hs c%0d addr", c), b_addr, 32'h2002);
      end else if (c == 6) begin
        chk("hs c6 pause", 32'(b_pause), 32'd0);
        chk("hs c6 we", 32'(b_we), 32'd1);
        chk("hs c6 wb", b_wb, 32'h0000BEEF);
      end else begin
        chk("hs c7 pause", 32'(b_pause), 32'd0);
        chk("hs c7 we", 32'(b_we), 32'd0);
      end
      next_cycle();
    end
    quiet();
    next_cycle();

    // Reset dropped in the middle of WAIT, then a clean LW.
    iv_a = 1'b1; mem_rr = 1'b1; reg_we = 1'b1; f3 = 3'b010; alu = 32'h2004;
    next_cycle();
    @(negedge clk);
    chk("rst pre pause", 32'(a_pause), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst async pause", 32'(a_pause), 32'd0);
    chk("rst async we", 32'(a_we), 32'd0);
    quiet();
    next_cycle();
    reset_n = 1'b1;
    #1;
    chk("rst idle pause", 32'(a_pause), 32'd0);
    next_cycle();
    for (int c = 0; c <= 5; c++) begin
      iv_a = (c <= 4); mem_rr = (c <= 4); reg_we = 1'b1; f3 = 3'b010;
      alu = 32'h2004;
      dcache = (c == 3) ? 32'hCAFEBABE : 32'h0;
      @(negedge clk);
      if (c <= 3) begin
        chk($sformatf("lw c%0d pause", c), 32'(a_pause), 32'd1);
        chk($sformatf("lw c%0d we", c), 32'(a_we), 32'd0);
      end else if (c == 4) begin
        chk("lw c4 we", 32'(a_we), 32'd1);
        chk("lw c4 wb", a_wb, 32'hCAFEBABE);
        chk("lw c4 addr", a_addr, 32'h2004);
      end else begin
        chk("lw c5 pause", 32'(a_pause), 32'd0);
        chk("lw c5 we", 32'(a_we), 32'd0);
      end
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
